// File: rtl/score_keeper_if.sv
// Board2 score keeper bus: player/start inputs and the four-digit display outputs.
interface score_keeper_if;
   logic       start;
   logic       pointP1;
   logic       pointP2;
   logic [3:0] scoreP1Tens;
   logic [3:0] scoreP1Ones;
   logic [3:0] scoreP2Tens;
   logic [3:0] scoreP2Ones;
   logic [3:0] digitEnable;
   logic [1:0] gameState;
   logic [1:0] winner;

   modport master (
      output start, pointP1, pointP2,
      input  scoreP1Tens, scoreP1Ones, scoreP2Tens, scoreP2Ones,
      input  digitEnable, gameState, winner
   );

   modport slave (
      input  start, pointP1, pointP2,
      output scoreP1Tens, scoreP1Ones, scoreP2Tens, scoreP2Ones,
      output digitEnable, gameState, winner
   );
endinterface

// File: rtl/score_keeper.sv
// Match score and game-state keeper: edge-detected point events, two-digit BCD
// scores, IDLE/PLAY/OVER match FSM with win rule, and winner-digit blinking.
module score_keeper #(
   parameter int unsigned WIN_SCORE    = 11,
   parameter int unsigned WIN_BY_TWO   = 1,
   parameter int unsigned BLINK_CYCLES = 25_000_000
) (
   input logic           clock,
   input logic           reset,
   score_keeper_if.slave bus
);
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned VAL_W   = 7;
   localparam int unsigned CMP_W   = 8;
   localparam int unsigned CNT_W   = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      OVER = 2'b10
   } state_t;

   state_t             state;
   logic               s_start, p_start, s_p1, p_p1, s_p2, p_p2;
   logic [DIGIT_W-1:0] p1_tens, p1_ones, p2_tens, p2_ones;
   logic [3:0]         digit_en;
   logic [1:0]         win_who;
   logic [CNT_W-1:0]   blink_cnt;

   logic               start_ev, p1_ev, p2_ev;
   logic [VAL_W-1:0]   p1_val, p2_val;
   logic               p1_win, p2_win;

   assign start_ev = s_start & ~p_start;
   assign p1_ev    = s_p1 & ~p_p1;
   assign p2_ev    = s_p2 & ~p_p2;

   assign p1_val = VAL_W'(p1_tens) * VAL_W'(10) + VAL_W'(p1_ones);
   assign p2_val = VAL_W'(p2_tens) * VAL_W'(10) + VAL_W'(p2_ones);

   // Win rule on registered scores; 99 wins regardless of lead
   always_comb begin
      p1_win = 1'b0;
      p2_win = 1'b0;
      if (p1_val == VAL_W'(99)) begin
         p1_win = 1'b1;
      end else if (p1_val >= VAL_W'(WIN_SCORE)) begin
         p1_win = (WIN_BY_TWO == 0) ||
                  (CMP_W'(p1_val) >= CMP_W'(p2_val) + CMP_W'(2));
      end
      if (p2_val == VAL_W'(99)) begin
         p2_win = 1'b1;
      end else if (p2_val >= VAL_W'(WIN_SCORE)) begin
         p2_win = (WIN_BY_TWO == 0) ||
                  (CMP_W'(p2_val) >= CMP_W'(p1_val) + CMP_W'(2));
      end
   end

   // Saturating two-digit BCD increment, returns {tens, ones}
   function automatic logic [2*DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] tens,
                                                    input logic [DIGIT_W-1:0] ones);
      logic [2*DIGIT_W-1:0] r;
      r = {tens, ones};
      if (tens == DIGIT_W'(9) && ones == DIGIT_W'(9)) begin
         r = {tens, ones};
      end else if (ones == DIGIT_W'(9)) begin
         r = {tens + DIGIT_W'(1), DIGIT_W'(0)};
      end else begin
         r = {tens, ones + DIGIT_W'(1)};
      end
      return r;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         s_start   <= 1'b0;
         p_start   <= 1'b0;
         s_p1      <= 1'b0;
         p_p1      <= 1'b0;
         s_p2      <= 1'b0;
         p_p2      <= 1'b0;
         p1_tens   <= '0;
         p1_ones   <= '0;
         p2_tens   <= '0;
         p2_ones   <= '0;
         digit_en  <= 4'b1111;
         win_who   <= 2'b00;
         blink_cnt <= '0;
      end else begin
         s_start <= bus.start;
         p_start <= s_start;
         s_p1    <= bus.pointP1;
         p_p1    <= s_p1;
         s_p2    <= bus.pointP2;
         p_p2    <= s_p2;

         case (state)
            IDLE: begin
               if (start_ev) begin
                  p1_tens  <= '0;
                  p1_ones  <= '0;
                  p2_tens  <= '0;
                  p2_ones  <= '0;
                  win_who  <= 2'b00;
                  digit_en <= 4'b1111;
                  state    <= PLAY;
               end
            end
            PLAY: begin
               // A decided match freezes scores before any further point lands
               if (p1_win || p2_win) begin
                  state     <= OVER;
                  win_who   <= p1_win ? 2'b01 : 2'b10;
                  blink_cnt <= '0;
                  digit_en  <= 4'b1111;
               end else if (p1_ev && !p2_ev) begin
                  {p1_tens, p1_ones} <= bcd_inc(p1_tens, p1_ones);
               end else if (p2_ev && !p1_ev) begin
                  {p2_tens, p2_ones} <= bcd_inc(p2_tens, p2_ones);
               end
            end
            OVER: begin
               if (start_ev) begin
                  p1_tens   <= '0;
                  p1_ones   <= '0;
                  p2_tens   <= '0;
                  p2_ones   <= '0;
                  win_who   <= 2'b00;
                  digit_en  <= 4'b1111;
                  blink_cnt <= '0;
                  state     <= PLAY;
               end else if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
                  blink_cnt <= '0;
                  if (win_who == 2'b01) begin
                     digit_en[3:2] <= ~digit_en[3:2];
                  end else begin
                     digit_en[1:0] <= ~digit_en[1:0];
                  end
               end else begin
                  blink_cnt <= blink_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.scoreP1Tens = p1_tens;
   assign bus.scoreP1Ones = p1_ones;
   assign bus.scoreP2Tens = p2_tens;
   assign bus.scoreP2Ones = p2_ones;
   assign bus.digitEnable = digit_en;
   assign bus.gameState   = state;
   assign bus.winner      = win_who;
endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (WIN_SCORE 11, win-by-two, blink 4).
module tb_score_keeper;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   score_keeper_if bus ();

   score_keeper #(
      .WIN_SCORE   (11),
      .WIN_BY_TWO  (1),
      .BLINK_CYCLES(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // m = {start, pointP2, pointP1}; high for one cycle, low for one cycle
   task automatic pulse(input logic [2:0] m);
      @(negedge clock);
      bus.start   = m[2];
      bus.pointP2 = m[1];
      bus.pointP1 = m[0];
      @(negedge clock);
      bus.start   = 1'b0;
      bus.pointP2 = 1'b0;
      bus.pointP1 = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic check_score(input string tag, input int a, input int b);
      check({tag, "_p1t"}, 8'(bus.scoreP1Tens), 8'(a / 10));
      check({tag, "_p1o"}, 8'(bus.scoreP1Ones), 8'(a % 10));
      check({tag, "_p2t"}, 8'(bus.scoreP2Tens), 8'(b / 10));
      check({tag, "_p2o"}, 8'(bus.scoreP2Ones), 8'(b % 10));
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.pointP1 = 1'b0;
      bus.pointP2 = 1'b0;
      #12;
      check("rst_state", 8'(bus.gameState), 8'h00);
      check("rst_en", 8'(bus.digitEnable), 8'h0f);
      check("rst_win", 8'(bus.winner), 8'h00);
      check_score("rst", 0, 0);
      @(negedge clock);
      reset = 1'b0;

      // Points in IDLE are ignored
      pulse(3'b001);
      wait_cycles(2);
      check_score("idle_pt", 0, 0);
      check("idle_state", 8'(bus.gameState), 8'h00);

      // Start: PLAY appears two edges after start rises
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      check("start_e1", 8'(bus.gameState), 8'h00);
      bus.start = 1'b0;
      @(negedge clock);
      check("start_e2", 8'(bus.gameState), 8'h01);
      check("start_en", 8'(bus.digitEnable), 8'h0f);
      check_score("start", 0, 0);

      // Ten P1 points exercise the BCD carry
      for (int i = 0; i < 10; i++) pulse(3'b001);
      wait_cycles(2);
      check_score("p1x10", 10, 0);
      check("p1x10_state", 8'(bus.gameState), 8'h01);

      for (int i = 0; i < 10; i++) pulse(3'b010);
      wait_cycles(2);
      check_score("p2x10", 10, 10);

      // Simultaneous points cancel
      pulse(3'b011);
      wait_cycles(2);
      check_score("both", 10, 10);

      // Held P1 for 5 cycles is one point; 11-10 stays in PLAY
      @(negedge clock);
      bus.pointP1 = 1'b1;
      wait_cycles(5);
      bus.pointP1 = 1'b0;
      wait_cycles(3);
      check_score("held", 11, 10);
      check("held_state", 8'(bus.gameState), 8'h01);
      check("held_en", 8'(bus.digitEnable), 8'h0f);

      // Winning point: score at k+1, OVER and winner at k+2
      @(negedge clock);
      bus.pointP1 = 1'b1;
      @(negedge clock);
      bus.pointP1 = 1'b0;
      check_score("win_k", 11, 10);
      @(negedge clock);
      check_score("win_k1", 12, 10);
      check("win_k1_state", 8'(bus.gameState), 8'h01);
      check("win_k1_win", 8'(bus.winner), 8'h00);
      @(negedge clock);
      check("win_k2_state", 8'(bus.gameState), 8'h02);
      check("win_k2_win", 8'(bus.winner), 8'h01);

      // Blink: 4 lit, 4 with P1 digits off, then lit again
      for (int i = 0; i < 11; i++) begin
         check($sformatf("blink%0d", i), 8'(bus.digitEnable),
               (((i / 4) % 2) == 1) ? 8'h03 : 8'h0f);
         @(negedge clock);
      end

      // Points ignored in OVER
      pulse(3'b010);
      wait_cycles(2);
      check_score("over_pt", 12, 10);
      check("over_state", 8'(bus.gameState), 8'h02);

      // Start from OVER clears everything
      pulse(3'b100);
      wait_cycles(1);
      check("restart_state", 8'(bus.gameState), 8'h01);
      check("restart_win", 8'(bus.winner), 8'h00);
      check("restart_en", 8'(bus.digitEnable), 8'h0f);
      check_score("restart", 0, 0);

      // Reach 7-5, then async reset between edges
      for (int i = 0; i < 7; i++) pulse(3'b001);
      for (int i = 0; i < 5; i++) pulse(3'b010);
      wait_cycles(2);
      check_score("s75", 7, 5);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("arst_state", 8'(bus.gameState), 8'h00);
      check("arst_en", 8'(bus.digitEnable), 8'h0f);
      check_score("arst", 0, 0);
      @(negedge clock);
      reset = 1'b0;
      pulse(3'b001);
      pulse(3'b010);
      wait_cycles(2);
      check_score("post_rst", 0, 0);
      check("post_rst_state", 8'(bus.gameState), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
